// File: rtl/traceback_processor.sv
// Traceback back-end: scores each traceback step, buffers the aligned pairs in a LIFO,
// then replays them start-to-end over a valid/ready port once the end marker arrives.
module traceback_processor #(
    parameter int CHAR_W   = 3,
    parameter int SCORE_W  = 9,
    parameter int MAX_LEN  = 32,
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int GAP      = -2,
    parameter logic [CHAR_W-1:0] GAP_CODE = '0,
    parameter int CNT_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_traceB,
    output logic                      in_ready,
    input  logic [CHAR_W-1:0]         SeqA_i_t,
    input  logic [CHAR_W-1:0]         SeqB_j_t,
    input  logic [2:0]                symbol,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHAR_W-1:0]         datoA,
    output logic [CHAR_W-1:0]         datoB,
    output logic signed [SCORE_W-1:0] final_score,
    output logic [CNT_W-1:0]          n_match,
    output logic [CNT_W-1:0]          n_mismatch,
    output logic [CNT_W-1:0]          n_gap,
    output logic                      done,
    output logic                      err
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic signed [SCORE_W:0]   D_MATCH    = (SCORE_W + 1)'(MATCH);
    localparam logic signed [SCORE_W:0]   D_MISMATCH = (SCORE_W + 1)'(MISMATCH);
    localparam logic signed [SCORE_W:0]   D_GAP      = (SCORE_W + 1)'(GAP);
    localparam logic signed [SCORE_W-1:0] S_MIN = {1'b1, {(SCORE_W - 1){1'b0}}};
    localparam logic signed [SCORE_W-1:0] S_MAX = {1'b0, {(SCORE_W - 1){1'b1}}};
    localparam logic [CNT_W-1:0]          SP_FULL = CNT_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, ERR} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        sp;
    logic [CHAR_W-1:0]       lifo_a [MAX_LEN];
    logic [CHAR_W-1:0]       lifo_b [MAX_LEN];

    logic                    accept, is_diag, is_up, is_left, is_end, is_step, is_bad, is_eq;
    logic                    inc_m, inc_mm, inc_g, push_ok;
    logic [CHAR_W-1:0]       push_a, push_b;
    logic [AW-1:0]           wr_idx, rd_idx;
    logic signed [SCORE_W:0] delta, base, sum;
    logic signed [SCORE_W-1:0] score_next;

    always_comb begin
        in_ready  = !rst && (state == IDLE || state == COLLECT);
        accept    = en_traceB && in_ready;
        is_diag   = (symbol == 3'b001);
        is_up     = (symbol == 3'b010);
        is_left   = (symbol == 3'b100);
        is_end    = (symbol == 3'b000);
        is_step   = is_diag || is_up || is_left;
        is_bad    = !(is_step || is_end);
        is_eq     = (SeqA_i_t == SeqB_j_t);
        inc_m     = is_diag && is_eq;
        inc_mm    = is_diag && !is_eq;
        inc_g     = is_up || is_left;
        push_a    = is_left ? GAP_CODE : SeqA_i_t;
        push_b    = is_up ? GAP_CODE : SeqB_j_t;
        // The first step of an alignment restarts from zero rather than accumulating.
        push_ok   = accept && is_step && (state == IDLE || sp != SP_FULL);
        wr_idx    = (state == IDLE) ? '0 : AW'(sp);
        rd_idx    = AW'(sp - 1'b1);
        delta     = is_diag ? (is_eq ? D_MATCH : D_MISMATCH) : D_GAP;
        base      = (state == IDLE) ? '0 : {final_score[SCORE_W-1], final_score};
        sum       = base + delta;
        if (sum[SCORE_W] != sum[SCORE_W-1])
            score_next = sum[SCORE_W] ? S_MIN : S_MAX;
        else
            score_next = sum[SCORE_W-1:0];
        out_valid = (state == DRAIN) && (sp != '0);
        datoA     = out_valid ? lifo_a[rd_idx] : GAP_CODE;
        datoB     = out_valid ? lifo_b[rd_idx] : GAP_CODE;
        err       = (state == ERR);
    end

    // Pair storage carries no reset; sp alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            lifo_a[wr_idx] <= push_a;
            lifo_b[wr_idx] <= push_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sp          <= '0;
            final_score <= '0;
            n_match     <= '0;
            n_mismatch  <= '0;
            n_gap       <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_bad) begin
                        state <= ERR;
                    end else if (accept && is_step) begin
                        final_score <= score_next;
                        n_match     <= CNT_W'(inc_m);
                        n_mismatch  <= CNT_W'(inc_mm);
                        n_gap       <= CNT_W'(inc_g);
                        sp          <= CNT_W'(1);
                        state       <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (is_bad || (is_step && sp == SP_FULL)) begin
                            state <= ERR;
                        end else if (is_end) begin
                            state <= DRAIN;
                        end else begin
                            final_score <= score_next;
                            n_match     <= n_match + CNT_W'(inc_m);
                            n_mismatch  <= n_mismatch + CNT_W'(inc_mm);
                            n_gap       <= n_gap + CNT_W'(inc_g);
                            sp          <= sp + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        sp <= sp - 1'b1;
                        if (sp == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_traceback_processor.sv
// Randomized and directed bench for traceback_processor against a queue-based alignment model.
module tb_traceback_processor;
    localparam int CW   = 3;
    localparam int SW   = 4;
    localparam int ML   = 8;
    localparam int CNTW = $clog2(ML + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_traceB = 1'b0;
    logic out_ready = 1'b0;
    logic [CW-1:0] SeqA_i_t = '0, SeqB_j_t = '0;
    logic [2:0] symbol = '0;
    logic in_ready, out_valid, done, err;
    logic [CW-1:0] datoA, datoB;
    logic signed [SW-1:0] final_score;
    logic [CNTW-1:0] n_match, n_mismatch, n_gap;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0 idle, 1 collecting, 2 draining, 3 error
    int m_mode = 0;
    int m_score = 0, m_match = 0, m_mis = 0, m_gap = 0;
    logic [5:0] m_q[$];

    traceback_processor #(.CHAR_W(CW), .SCORE_W(SW), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .en_traceB(en_traceB), .in_ready(in_ready),
        .SeqA_i_t(SeqA_i_t), .SeqB_j_t(SeqB_j_t), .symbol(symbol),
        .out_valid(out_valid), .out_ready(out_ready), .datoA(datoA), .datoB(datoB),
        .final_score(final_score), .n_match(n_match), .n_mismatch(n_mismatch),
        .n_gap(n_gap), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [2:0] sym, input logic [2:0] a, input logic [2:0] b);
        int d;
        logic [2:0] pa, pb;
        if (m_mode == 0 || m_mode == 1) begin
            if (!(sym inside {3'b000, 3'b001, 3'b010, 3'b100})) begin
                m_mode = 3;
            end else if (sym == 3'b000) begin
                if (m_mode == 1) m_mode = 2;
            end else if (m_mode == 1 && m_q.size() == ML) begin
                m_mode = 3;
            end else begin
                if (m_mode == 0) begin
                    m_q.delete();
                    m_score = 0; m_match = 0; m_mis = 0; m_gap = 0;
                    m_mode = 1;
                end
                pa = a; pb = b;
                if (sym == 3'b001) begin
                    d = (a == b) ? 1 : -1;
                    if (a == b) m_match++; else m_mis++;
                end else begin
                    d = -2;
                    m_gap++;
                    if (sym == 3'b010) pb = 3'b000; else pa = 3'b000;
                end
                m_score = m_score + d;
                if (m_score > 7) m_score = 7;
                if (m_score < -8) m_score = -8;
                m_q.push_back({pa, pb});
            end
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_score"}, $signed(final_score), m_score);
        check({tag, "_nmatch"}, n_match, m_match);
        check({tag, "_nmis"}, n_mismatch, m_mis);
        check({tag, "_ngap"}, n_gap, m_gap);
        check({tag, "_err"}, err, (m_mode == 3) ? 1 : 0);
        check({tag, "_in_ready"}, in_ready, (m_mode < 2) ? 1 : 0);
    endtask

    task automatic step(input logic [2:0] sym, input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        en_traceB = 1'b1; symbol = sym; SeqA_i_t = a; SeqB_j_t = b;
        check("step_in_ready", in_ready, 1);
        @(posedge clk);
        model_accept(sym, a, b);
        #1;
        check_stats("step");
    endtask

    // style 0: ready high, 1: toggling, 2: random
    task automatic drain(input int style);
        int cyc = 0;
        int len;
        logic [5:0] top;
        len = m_q.size();
        while (m_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            en_traceB = 1'b0;
            case (style)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            top = m_q[$];
            check("drain_valid", out_valid, 1);
            check("drain_datoA", datoA, top[5:3]);
            check("drain_datoB", datoB, top[2:0]);
            check("drain_done_early", done, 0);
            @(posedge clk);
            if (out_ready) void'(m_q.pop_back());
            cyc++;
        end
        if (m_q.size() != 0) check("drain_timeout", m_q.size(), 0);
        m_mode = 0;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_done", done, 1);
        check("drain_valid_end", out_valid, 0);
        check_stats("drain_hold");
        @(negedge clk);
        check("drain_done_pulse", done, 0);
        $display("drained %0d pairs in %0d cycles (style %0d), score %0d", len, cyc, style, m_score);
    endtask

    task automatic err_hold(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en_traceB = 1'b1;
            symbol = 3'b001; SeqA_i_t = 3'd1; SeqB_j_t = 3'd1;
            out_ready = 1'b1;
            check({tag, "_valid"}, out_valid, 0);
            check_stats(tag);
        end
        @(negedge clk);
        en_traceB = 1'b0; out_ready = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        en_traceB = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_in_ready"}, in_ready, 0);
        check({tag, "_rst_valid"}, out_valid, 0);
        check({tag, "_rst_datoA"}, datoA, 0);
        check({tag, "_rst_datoB"}, datoB, 0);
        check({tag, "_rst_score"}, $signed(final_score), 0);
        check({tag, "_rst_cnt"}, n_match + n_mismatch + n_gap, 0);
        check({tag, "_rst_done"}, done, 0);
        check({tag, "_rst_err"}, err, 0);
        m_q.delete();
        m_mode = 0; m_score = 0; m_match = 0; m_mis = 0; m_gap = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, "_post_rst_in_ready"}, in_ready, 1);
    endtask

    task automatic nominal();
        step(3'b100, 3'b000, 3'b110);
        step(3'b001, 3'b001, 3'b001);
        step(3'b001, 3'b011, 3'b011);
        step(3'b010, 3'b110, 3'b000);
        step(3'b001, 3'b100, 3'b100);
        step(3'b001, 3'b110, 3'b001);
        check("nom_score", $signed(final_score), -2);
        check("nom_match", n_match, 3);
        check("nom_mis", n_mismatch, 1);
        check("nom_gap", n_gap, 2);
        step(3'b000, 3'b000, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("init");

        nominal();
        drain(0);
        nominal();
        drain(1);

        // end symbol in IDLE is ignored
        step(3'b000, 3'b010, 3'b101);

        // reset mid-COLLECT and mid-DRAIN
        step(3'b001, 3'b010, 3'b010);
        step(3'b010, 3'b011, 3'b000);
        do_reset("mid_collect");
        step(3'b001, 3'b010, 3'b010);
        step(3'b100, 3'b000, 3'b111);
        step(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        en_traceB = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        do_reset("mid_drain");

        // overflow: the (ML+1)-th step raises err
        for (int i = 0; i < ML; i++) step(3'b001, 3'(i), 3'(i));
        step(3'b001, 3'b101, 3'b101);
        check("ovf_err", err, 1);
        err_hold("ovf", 4);
        do_reset("ovf");

        // invalid symbol leaves stats untouched
        step(3'b001, 3'b001, 3'b010);
        step(3'b100, 3'b000, 3'b011);
        step(3'b011, 3'b001, 3'b001);
        check("inv_err", err, 1);
        check("inv_score", $signed(final_score), -3);
        err_hold("inv", 3);
        do_reset("inv");

        // saturation then reload
        for (int i = 0; i < 6; i++) step(3'b010, 3'b011, 3'b000);
        check("sat_score", $signed(final_score), -8);
        step(3'b000, 3'b000, 3'b000);
        drain(2);
        step(3'b001, 3'b011, 3'b011);
        check("reload_score", $signed(final_score), 1);
        check("reload_gap", n_gap, 0);
        check("reload_match", n_match, 1);
        step(3'b000, 3'b000, 3'b000);
        drain(0);

        // randomized alignments
        for (int r = 0; r < 25; r++) begin
            int len;
            if ($urandom_range(0, 3) == 0) step(3'b000, 3'($urandom), 3'($urandom));
            len = $urandom_range(1, ML);
            for (int k = 0; k < len; k++) begin
                logic [2:0] sym, a, b;
                case ($urandom_range(0, 2))
                    0: sym = 3'b001;
                    1: sym = 3'b010;
                    default: sym = 3'b100;
                endcase
                a = 3'($urandom);
                b = ($urandom_range(0, 1) == 1) ? a : 3'($urandom);
                step(sym, a, b);
            end
            step(3'b000, 3'b000, 3'b000);
            drain(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/traceback_processor.md
# traceback_processor

Parametrised traceback back-end for the Needleman-Wunsch datapath. Consumes one traceback step per cycle (direction symbol plus the two sequence characters at the current cell), accumulates the alignment score with configurable weights and saturation, and collects match/mismatch/gap statistics. Traceback produces pairs end-to-start, so the block buffers the aligned pairs in an internal LIFO and, after the end-of-traceback marker, drains them in forward order over a valid/ready port. Sits between the traceback address walker and the alignment output/UART stage.

## Interface
- CHAR_W, 3: character and symbol code width.
- SCORE_W, 9: signed score width.
- MAX_LEN, 32: LIFO depth; maximum alignment length (≥2).
- MATCH, 1: signed score delta for a diagonal step with equal characters.
- MISMATCH, -1: signed delta for a diagonal step with different characters.
- GAP, -2: signed delta for an up or left step.
- GAP_CODE, 3'b000: character code emitted for a gap.
- CNT_W, $clog2(MAX_LEN+1): width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en_traceB  in  1  step valid.
- in_ready  out  1  step accepted when en_traceB && in_ready.
- SeqA_i_t  in  CHAR_W  character of sequence A at the current cell.
- SeqB_j_t  in  CHAR_W  character of sequence B at the current cell.
- symbol  in  3  direction: 001 diagonal, 010 up, 100 left, 000 end.
- out_valid  out  1  aligned pair available.
- out_ready  in  1  consumer accepts the pair.
- datoA  out  CHAR_W  aligned character A, or GAP_CODE.
- datoB  out  CHAR_W  aligned character B, or GAP_CODE.
- final_score  out  SCORE_W  signed accumulated score.
- n_match, n_mismatch, n_gap  out  CNT_W each  step statistics.
- done  out  1  one-cycle pulse when the last pair is popped.
- err  out  1  sticky error flag.

## Operation
- States: IDLE, COLLECT, DRAIN, ERR.
- in_ready is 1 in IDLE and COLLECT, and 0 in DRAIN and ERR. While rst is high, in_ready is 0.
- Step mapping, on acceptance:
  - Diagonal: push (SeqA, SeqB); delta is MATCH if SeqA == SeqB, else MISMATCH; increment n_match or n_mismatch.
  - Up: push (SeqA, GAP_CODE); delta GAP; increment n_gap.
  - Left: push (GAP_CODE, SeqB); delta GAP; increment n_gap.
- IDLE:
  - An accepted non-end step reloads everything instead of accumulating: final_score = delta, counters = that step only, stack pointer sp = 1. Go to COLLECT.
  - An accepted end symbol in IDLE is ignored.
- COLLECT:
  - An accepted step pushes and accumulates.
  - An accepted end symbol pushes nothing and goes to DRAIN.
- Score arithmetic: SCORE_W+1-bit signed sum, saturated to [-2^(SCORE_W-1), 2^(SCORE_W-1)-1].
- DRAIN:
  - out_valid = (sp > 0); datoA/datoB = LIFO[sp-1], combinationally from the register array.
  - A pop occurs on out_valid && out_ready.
  - The pop that takes sp from 1 to 0 pulses done on the following cycle and returns to IDLE.
- ERR entry from COLLECT, or from IDLE for the invalid-symbol case:
  - Accepted symbol not in {000, 001, 010, 100}.
  - Accepted non-end step while sp == MAX_LEN (overflow). The offending step is not pushed.
- ERR behaviour:
  - err = 1, out_valid = 0, in_ready = 0.
  - Exit only via rst.
- final_score and counters hold after done until the next alignment's first accepted step.
- Reset values: state IDLE, sp 0, final_score 0, all counters 0, out_valid 0, datoA/datoB = GAP_CODE, done 0, err 0.

## Timing
- Throughput: one step per cycle in COLLECT; one pop per cycle in DRAIN.
- final_score and counters reflect a step on the edge that accepts it; they are registered, so visible the next cycle.
- End accepted at edge N: out_valid is 1 from cycle N+1.
- DRAIN of L pairs with out_ready held high takes L cycles; done is high in the cycle after the last pop.
- DRAIN with L = 0 (end directly after an overflow-free empty COLLECT) cannot occur, because COLLECT implies sp ≥ 1.
- rst mid-COLLECT or mid-DRAIN: immediate return to reset values, with no partial output.
- out_ready low stalls: datoA/datoB and out_valid are held stable.

## Test plan
- Reset:
  - Assert rst mid-stream → all outputs at reset values asynchronously, before the next clk edge.
  - After release, in_ready = 1.
- Nominal path, pair codes G=001, T=011, A=100, C=110:
  - Steps (symbol 100, B=C), (001, G/G), (001, T/T), (010, A=C), (001, A/A), (001, C/G), then 000.
  - Expected totals: final_score = -2, n_match 3, n_mismatch 1, n_gap 2.
  - Expected drain order: (C,G), (A,A), (C,000), (T,T), (G,G), (000,C).
  - done follows the last pop.
- Backpressure:
  - Toggle out_ready 1/0 every cycle during DRAIN → each pair is held while out_ready is low; no loss or duplication; done follows the sixth pop.
- Overflow, MAX_LEN=4:
  - Fifth diagonal step → err = 1, in_ready = 0, out_valid stays 0 until rst.
- Invalid symbol:
  - symbol 011 in COLLECT → ERR; final_score and counters are unchanged by that step.
- Saturation and reload, SCORE_W=4, GAP=-2:
  - Six up steps → final_score saturates at -8.
  - After drain, a new first diagonal match step → final_score = 1, n_gap = 0.
